// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the request-legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int WORD_BYTES = 4;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3[2] || (f3 == 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store merge into a
// previously read cache word. off_i is expected to be naturally aligned.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'b0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'b0, half_sel};
      default: load_o = word_i;
    endcase

    store_o = wdata_i;
    if (funct3_i[1:0] == 2'b00) begin
      store_o = word_i;
      store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (funct3_i[1:0] == 2'b01) begin
      store_o = word_i;
      if (off_i[1]) store_o[31:16] = wdata_i[15:0];
      else          store_o[15:0]  = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between memory stage and data cache: word-aligned cache
// access, RMW for SB/SH, hit-wait timeout. Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy,
  output logic              dc_valid,
  output logic              dc_write_enable,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_write_data,
  input  logic [31:0]       dc_read_data,
  input  logic              dc_hit
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q, rdata_q;

  logic        hit_ok, tmo, misalign, accept;
  logic [1:0]  off_eff;
  logic [31:0] align_word, load_fmt, store_word;

  assign accept = (state_q == S_IDLE) && req_valid;
  // The first cycle of every phase carries the previous lookup's hit.
  assign hit_ok = dc_hit && (cnt_q != '0);
  assign tmo    = (MAX_WAIT != 0) && (cnt_q >= CNT_LIM);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (f3_q[1:0])
      2'b00:   off_eff = addr_q[1:0];
      2'b01:   off_eff = {addr_q[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  assign align_word = (state_q == S_RD) ? dc_read_data : word_q;

  lsu_align u_align (
    .funct3_i (f3_q),
    .off_i    (off_eff),
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .load_o   (load_fmt),
    .store_o  (store_word)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        fault_d = f3_illegal(req_store, req_funct3) || misalign;
        if (fault_d)                                   state_d = S_RESP;
        else if (req_store && (req_funct3 == F3_W))    state_d = S_WR;
        else                                           state_d = S_RD;
      end
      S_RD: if (hit_ok) begin
        state_d = store_q ? S_WR : S_RESP;
      end else if (tmo) begin
        state_d = S_RESP;
        fault_d = 1'b1;
      end
      S_WR: if (hit_ok) begin
        state_d = S_RESP;
      end else if (tmo) begin
        state_d = S_RESP;
        fault_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if ((state_q == S_RD) && hit_ok) begin
      word_q  <= dc_read_data;
      rdata_q <= load_fmt;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign dc_valid        = (state_q == S_RD) || (state_q == S_WR);
  assign dc_write_enable = (state_q == S_WR);
  assign dc_addr         = dc_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dc_write_data   = dc_write_enable ? store_word : '0;
  assign rsp_valid       = (state_q == S_RESP);
  assign rsp_fault       = rsp_valid && fault_q;
  assign rsp_rdata       = (rsp_valid && !fault_q && !store_q) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized requests against a
// byte-lane/latency reference model, with a cache responder and response monitor.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_rdata;
  logic        dc_valid, dc_write_enable, dc_hit;
  logic [31:0] dc_addr, dc_write_data, dc_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .busy(busy), .dc_valid(dc_valid), .dc_write_enable(dc_write_enable),
    .dc_addr(dc_addr), .dc_write_data(dc_write_data),
    .dc_read_data(dc_read_data), .dc_hit(dc_hit)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rd_delay = 1;
  int          wr_delay = 1;
  logic [31:0] cache_word = '0;
  logic [31:0] exp_wr = '0;
  logic [31:0] exp_daddr = '0;
  logic        exp_access = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_illegal(input logic st, input logic [2:0] f);
    if (st) return f > 3'd2;
    return (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
  endfunction

  function automatic logic m_misal(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % acc_size(f)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_off(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = acc_size(f);
    return ((a % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = acc_size(f);
    v = w >> (8 * lane_off(f, a));
    if (sz == 1) v = v & 32'h0000_00FF;
    if (sz == 2) v = v & 32'h0000_FFFF;
    if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] d, input logic [31:0] w);
    logic [31:0] mask;
    int sz, off;
    sz  = acc_size(f);
    off = lane_off(f, a);
    if (sz == 4)      mask = 32'hFFFF_FFFF;
    else if (sz == 2) mask = 32'h0000_FFFF << (8 * off);
    else              mask = 32'h0000_00FF << (8 * off);
    return (w & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  function automatic int phase_len(input int d);
    return (d <= MW) ? d + 1 : MW + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) fail_now("req_ready_timeout");
  endtask

  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] w, input int rdd, input int wrd);
    exp_t e;
    logic bad, has_rd;
    int   k;
    wait_ready();
    bad        = m_illegal(st, f) || (!m_illegal(st, f) && m_misal(f, a));
    cache_word = w;
    rd_delay   = rdd;
    wr_delay   = wrd;
    exp_daddr  = a & 32'hFFFF_FFFC;
    exp_access = !bad;
    exp_wr     = bad ? 32'h0 : m_store(f, a, d, w);
    e.fault = bad;
    e.lat   = 1;
    if (!bad) begin
      has_rd = !st || (f != 3'd2);
      if (has_rd) begin
        e.lat += phase_len(rdd);
        if (rdd > MW) e.fault = 1'b1;
      end
      if (st && !e.fault) begin
        e.lat += phase_len(wrd);
        if (wrd > MW) e.fault = 1'b1;
      end
    end
    e.rdata = (!st && !e.fault) ? m_load(f, a, w) : 32'h0;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = d;
    acc_cyc    = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      fail_now("response_timeout");
      sb_q.delete();
    end
  endtask

  // ---------------- cache responder ----------------
  initial begin
    int   ph, dly;
    logic pv, pwe;
    ph = 0; pv = 1'b0; pwe = 1'b0;
    forever begin
      @(negedge clk);
      if (dc_valid && (!pv || dc_write_enable != pwe)) ph = 0;
      else ph = ph + 1;
      pv  = dc_valid;
      pwe = dc_write_enable;
      dc_read_data = cache_word;
      if (dc_valid) begin
        dly = dc_write_enable ? wr_delay : rd_delay;
        // stale hit always presented in a phase's first cycle
        dc_hit = (ph == 0) ? 1'b1 : (ph >= dly);
        if (!exp_access) fail_now("dc_valid_on_faulting_request");
        if (ph == 0) chk("dc_addr", dc_addr, exp_daddr);
        if (dc_write_enable && ph >= 1 && dc_hit) chk("dc_write_data", dc_write_data, exp_wr);
      end else begin
        dc_hit = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("dc_valid_in_resp", {31'b0, dc_valid}, 32'h0);
        if (sb_q.size() == 0) begin
          fail_now("unexpected_rsp_valid");
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        st;
    logic [2:0]  f;
    logic [31:0] a;
    int          k;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; dc_hit = 1'b0; dc_read_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_dc_valid", {31'b0, dc_valid}, 32'h0);
    chk("reset_dc_we", {31'b0, dc_write_enable}, 32'h0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_dc_addr", dc_addr, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;

    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1, 1);
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'hBEEF_0001, 1, 1);
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AA, 32'h1122_3344, 1, 1);
    issue(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,         1, 1);
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0,         32'h1234_5678, 9, 1);
    issue(1'b0, 3'b010, 32'h0000_5002, 32'h0,         32'hCAFE_F00D, 1, 1);
    issue(1'b1, 3'b001, 32'h0000_7002, 32'h0000_5566, 32'hA1B2_C3D4, 3, 2);
    issue(1'b1, 3'b000, 32'h0000_7003, 32'h0000_0077, 32'hA1B2_C3D4, 2, 9);
    issue(1'b0, 3'b011, 32'h0000_8000, 32'h0,         32'hFFFF_FFFF, 1, 1);
    issue(1'b1, 3'b100, 32'h0000_8000, 32'h1,         32'hFFFF_FFFF, 1, 1);

    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else if (st) f = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        f = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
      end
      a = $urandom;
      issue(st, f, a, $urandom, $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
    end

    // reset while the RD phase is waiting: no response may follow
    wait_ready();
    cache_word = 32'h0BAD_0BAD; rd_delay = 9; wr_delay = 9;
    exp_daddr  = 32'h0000_9000; exp_access = 1'b1;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_9000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_before_reset", {31'b0, dc_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_dc_valid", {31'b0, dc_valid}, 32'h0);
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    chk("midreset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    issue(1'b0, 3'b100, 32'h0000_A001, 32'h0, 32'h0000_9C00, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
